alu_ctrl_encoder: RTL and testbench
===================================

Name: alu_ctrl_encoder

Overview:
- Opcode-side counterpart of the ALU5 control decoder.
- Accepts one ALU operation per handshake from the instruction sequencer.
- Encodes it into the 6-bit control word Ctrl0..Ctrl5 and drives that word to the ALU datapath and decoders under a valid/ready handshake.
- Multi-bit shifts and rotates are serialised into repeated 1-bit ALU steps, so the datapath only ever sees single-step control words.

Parameters:
- OP_W, 4, opcode width.
- CNT_W, 4, shift-amount width; a maximum of 2^CNT_W-1 steps.

Ports:
- clk  input  1  system clock; all state is updated on the rising edge.
- rst  input  1  synchronous, active-high reset.
- op_valid  input  1  the upstream opcode is valid.
- op_ready  output  1  the block can accept an opcode.
- op_code  input  OP_W  operation code; encoding is given under Behaviour.
- op_shamt  input  CNT_W  step count for opcodes 9..14; ignored for all other opcodes.
- ctrl  output  6  control word; ctrl[0] = Ctrl0 … ctrl[5] = Ctrl5.
- ctrl_valid  output  1  ctrl holds one ALU step.
- ctrl_ready  input  1  the ALU consumes the step this cycle.
- ctrl_last  output  1  the current step is the final step of the operation.
- op_err  output  1  one-cycle pulse when an illegal opcode is accepted.
- busy  output  1  the block is not in IDLE.

Behaviour:
- Opcode → ctrl{5..0}, shown with Ctrl0 first:
  - 0 ADD 010010
  - 1 SUB 010001
  - 2 OR 001010
  - 3 NOT 001100
  - 4 XOR 001110
  - 5 AND 000110
  - 6 MOV 000000
  - 7 INC 011011
  - 8 DEC 011000
  - 9 SLA 100100
  - 10 SLL 100000
  - 11 ROL 100010
  - 12 SRA 101100
  - 13 SRL 101000
  - 14 ROR 101010
  - 15 illegal
- Reset: state IDLE, op_ready=1, ctrl=000000, ctrl_valid=0, ctrl_last=0, op_err=0, busy=0, step counter=0.
- FSM states: IDLE and ISSUE.
- IDLE:
  - op_ready=1.
  - An opcode is accepted when op_valid&op_ready.
  - On accepting opcode 15: op_err=1 for the next cycle, state stays IDLE, ctrl_valid stays 0.
  - On accepting opcodes 0..8: ctrl is registered next cycle, ctrl_valid=1, ctrl_last=1, state goes to ISSUE, remaining count=1.
  - On accepting opcodes 9..14 with op_shamt=N≥1: ctrl is registered next cycle, ctrl_valid=1, remaining count=N, ctrl_last=(N==1), state goes to ISSUE.
  - On accepting opcodes 9..14 with op_shamt=0: the block issues one MOV step (000000, ctrl_last=1) so the result register is still written.
- ISSUE:
  - op_ready=0 and busy=1.
  - ctrl and ctrl_valid hold stable while ctrl_ready=0; there is no timeout.
  - On ctrl_valid&ctrl_ready: count decrements and ctrl_last=(count==2) for the next step.
  - When count reaches 1 and that step is accepted: ctrl_valid=0, ctrl=000000, and the state returns to IDLE.
- Latency:
  - From opcode acceptance to the first ctrl_valid: 1 cycle.
  - N-step shift with ctrl_ready held at 1: N consecutive ctrl_valid cycles, then IDLE.
- No back-to-back overlap: op_ready deasserts the cycle after acceptance, so the minimum issue interval between single-step ops is 2 cycles.
- ctrl changes only on acceptance or on a step boundary; it never glitches mid-step.
- Reset asserted mid-ISSUE: all outputs return to reset values on the next edge and the in-flight operation is discarded without a final step.
- op_valid with op_ready=0 is ignored; upstream holds the request.
- The counter is CNT_W bits with no wrap: the maximum count of 15 is loaded directly, and a decrement from 1 never occurs because the block leaves ISSUE at that point.

Decomposition:
- Shared package alu_ctrl_pkg holds:
  - opcode localparams OP_ADD..OP_ROR and OP_ILLEGAL=15;
  - the 6-bit control-word constants CW_ADD..CW_ROR;
  - the is_shift(op) helper.
  - alu_ctrl_encoder uses the same constants so that the control words match the decoders' truth tables.
- Natural sub-module: alu_ctrl_lut, a purely combinational map from opcode to {cw, is_shift, illegal}. The FSM, counter and handshake logic stay in the top-level module.

Test Plan:
- ADD, with ctrl_ready=1: op_code=0 accepted → next cycle ctrl=010010, ctrl_valid=1, ctrl_last=1 → then IDLE, op_ready=1.
- SLL with op_shamt=3 and ctrl_ready=1 → three consecutive cycles of ctrl=100000; ctrl_last only on the 3rd; busy=1 throughout.
- ROR with op_shamt=2 and ctrl_ready low for 4 cycles during step 1 → ctrl=101010 held stable; exactly 2 handshakes in total.
- op_code=15 → op_err pulses for 1 cycle, ctrl_valid never asserts, op_ready stays 1.
- SRA with op_shamt=0 → a single ctrl=000000 step with ctrl_last=1.
- rst=1 during step 2 of an SLA with op_shamt=5 → next cycle ctrl_valid=0, ctrl=000000, op_ready=1; a following MOV issues normally.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg: opcodes, ALU5 control words and FSM state shared with the decoders
package alu_ctrl_pkg;
  localparam logic [3:0] OP_ADD     = 4'd0;
  localparam logic [3:0] OP_SUB     = 4'd1;
  localparam logic [3:0] OP_OR      = 4'd2;
  localparam logic [3:0] OP_NOT     = 4'd3;
  localparam logic [3:0] OP_XOR     = 4'd4;
  localparam logic [3:0] OP_AND     = 4'd5;
  localparam logic [3:0] OP_MOV     = 4'd6;
  localparam logic [3:0] OP_INC     = 4'd7;
  localparam logic [3:0] OP_DEC     = 4'd8;
  localparam logic [3:0] OP_SLA     = 4'd9;
  localparam logic [3:0] OP_SLL     = 4'd10;
  localparam logic [3:0] OP_ROL     = 4'd11;
  localparam logic [3:0] OP_SRA     = 4'd12;
  localparam logic [3:0] OP_SRL     = 4'd13;
  localparam logic [3:0] OP_ROR     = 4'd14;
  localparam logic [3:0] OP_ILLEGAL = 4'd15;
  // Bit i of each word is Ctrl<i>, so the literals read Ctrl5 down to Ctrl0
  localparam logic [5:0] CW_ADD = 6'b010010;
  localparam logic [5:0] CW_SUB = 6'b100010;
  localparam logic [5:0] CW_OR  = 6'b010100;
  localparam logic [5:0] CW_NOT = 6'b001100;
  localparam logic [5:0] CW_XOR = 6'b011100;
  localparam logic [5:0] CW_AND = 6'b011000;
  localparam logic [5:0] CW_MOV = 6'b000000;
  localparam logic [5:0] CW_INC = 6'b110110;
  localparam logic [5:0] CW_DEC = 6'b000110;
  localparam logic [5:0] CW_SLA = 6'b001001;
  localparam logic [5:0] CW_SLL = 6'b000001;
  localparam logic [5:0] CW_ROL = 6'b010001;
  localparam logic [5:0] CW_SRA = 6'b001101;
  localparam logic [5:0] CW_SRL = 6'b000101;
  localparam logic [5:0] CW_ROR = 6'b010101;
  typedef enum logic {S_IDLE, S_ISSUE} state_t;
  function automatic logic is_shift(input logic [3:0] op);
    return op >= OP_SLA && op <= OP_ROR;
  endfunction
endpackage

// File: rtl/alu_ctrl_lut.sv
// alu_ctrl_lut: combinational opcode to control-word map
module alu_ctrl_lut
  import alu_ctrl_pkg::*;
(
  input  logic [3:0] op,
  output logic [5:0] cw,
  output logic       shift,
  output logic       illegal
);
  always_comb begin
    cw = CW_MOV;
    case (op)
      OP_ADD:  cw = CW_ADD;
      OP_SUB:  cw = CW_SUB;
      OP_OR:   cw = CW_OR;
      OP_NOT:  cw = CW_NOT;
      OP_XOR:  cw = CW_XOR;
      OP_AND:  cw = CW_AND;
      OP_INC:  cw = CW_INC;
      OP_DEC:  cw = CW_DEC;
      OP_SLA:  cw = CW_SLA;
      OP_SLL:  cw = CW_SLL;
      OP_ROL:  cw = CW_ROL;
      OP_SRA:  cw = CW_SRA;
      OP_SRL:  cw = CW_SRL;
      OP_ROR:  cw = CW_ROR;
      default: cw = CW_MOV;
    endcase
  end
  assign shift   = is_shift(op);
  assign illegal = op == OP_ILLEGAL;
endmodule

// File: rtl/alu_ctrl_encoder.sv
// alu_ctrl_encoder: opcode to ALU5 control-word issuer, serialising shifts into 1-bit steps
module alu_ctrl_encoder
  import alu_ctrl_pkg::*;
#(
  parameter int OP_W  = 4,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [OP_W-1:0]  op_code,
  input  logic [CNT_W-1:0] op_shamt,
  output logic [5:0]       ctrl,
  output logic             ctrl_valid,
  input  logic             ctrl_ready,
  output logic             ctrl_last,
  output logic             op_err,
  output logic             busy
);
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [5:0]       ctrl_q, ctrl_d, cw;
  logic             last_q, last_d, err_q, err_d;
  logic             shift, illegal, accept, zero_shamt, fin;
  alu_ctrl_lut u_lut (
    .op      (op_code[3:0]),
    .cw      (cw),
    .shift   (shift),
    .illegal (illegal)
  );
  assign op_ready   = state_q == S_IDLE;
  assign busy       = state_q == S_ISSUE;
  assign ctrl_valid = busy;
  assign ctrl       = ctrl_q;
  assign ctrl_last  = last_q;
  assign op_err     = err_q;
  assign accept     = op_valid && op_ready;
  assign zero_shamt = op_shamt == '0;
  assign fin        = cnt_q == CNT_W'(1);
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ctrl_q  <= CW_MOV;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ctrl_q  <= ctrl_d;
      last_q  <= last_d;
      err_q   <= err_d;
    end
  end
  // A zero-length shift still issues one MOV step so the result register is written
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ctrl_d  = ctrl_q;
    last_d  = last_q;
    err_d   = 1'b0;
    if (state_q == S_IDLE) begin
      err_d = accept && illegal;
      if (accept && !illegal) begin
        state_d = S_ISSUE;
        ctrl_d  = (shift && zero_shamt) ? CW_MOV : cw;
        cnt_d   = (shift && !zero_shamt) ? op_shamt : CNT_W'(1);
        last_d  = cnt_d == CNT_W'(1);
      end
    end else if (ctrl_ready) begin
      state_d = fin ? S_IDLE : S_ISSUE;
      cnt_d   = fin ? '0 : cnt_q - CNT_W'(1);
      ctrl_d  = fin ? CW_MOV : ctrl_q;
      last_d  = !fin && cnt_q == CNT_W'(2);
    end
  end
endmodule

// File: tb/tb_alu_ctrl_encoder.sv
// tb_alu_ctrl_encoder: scoreboard bench, expected ALU steps queued at issue and checked on handshake
module tb_alu_ctrl_encoder;
  logic       clk = 1'b0, rst = 1'b1;
  logic       op_valid = 1'b0, op_ready;
  logic [3:0] op_code = '0, op_shamt = '0;
  logic [5:0] ctrl;
  logic       ctrl_valid, ctrl_ready = 1'b0, ctrl_last, op_err, busy;
  int checks = 0, errors = 0, exp_err = 0, seen_err = 0;
  logic [6:0] q[$];
  alu_ctrl_encoder dut (
    .clk        (clk),
    .rst        (rst),
    .op_valid   (op_valid),
    .op_ready   (op_ready),
    .op_code    (op_code),
    .op_shamt   (op_shamt),
    .ctrl       (ctrl),
    .ctrl_valid (ctrl_valid),
    .ctrl_ready (ctrl_ready),
    .ctrl_last  (ctrl_last),
    .op_err     (op_err),
    .busy       (busy)
  );
  always #5 clk = ~clk;
  // Table literals are written Ctrl0 first, then flipped into ctrl[0]=Ctrl0 order
  function automatic logic [5:0] cw_of(input int op);
    logic [5:0] s, r;
    case (op)
      0: s = 6'b010010;  1: s = 6'b010001;  2: s = 6'b001010;  3: s = 6'b001100;
      4: s = 6'b001110;  5: s = 6'b000110;  6: s = 6'b000000;  7: s = 6'b011011;
      8: s = 6'b011000;  9: s = 6'b100100; 10: s = 6'b100000; 11: s = 6'b100010;
      12: s = 6'b101100; 13: s = 6'b101000; 14: s = 6'b101010; default: s = 6'b000000;
    endcase
    for (int i = 0; i < 6; i++) r[i] = s[5-i];
    return r;
  endfunction
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic send(input int op, input int sh);
    if (op == 15) exp_err++;
    else if (op >= 9 && sh != 0)
      for (int i = 1; i <= sh; i++) q.push_back({cw_of(op), i == sh});
    else q.push_back({(op >= 9) ? 6'b000000 : cw_of(op), 1'b1});
    op_code = 4'(op);
    op_shamt = 4'(sh);
    op_valid = 1'b1;
    @(posedge clk);
    #1 op_valid = 1'b0;
  endtask
  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (!op_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", int'(op_ready), 1);
    chk("queue_drained", q.size(), 0);
  endtask
  task automatic chk_reset_state(input string tag);
    chk({tag, "_op_ready"}, int'(op_ready), 1);
    chk({tag, "_ctrl"}, int'(ctrl), 0);
    chk({tag, "_ctrl_valid"}, int'(ctrl_valid), 0);
    chk({tag, "_ctrl_last"}, int'(ctrl_last), 0);
    chk({tag, "_op_err"}, int'(op_err), 0);
    chk({tag, "_busy"}, int'(busy), 0);
  endtask
  always @(negedge clk) begin
    if (!rst) begin
      chk("busy_vs_valid", int'(busy), int'(ctrl_valid));
      chk("ready_vs_busy", int'(op_ready), int'(!busy));
      if (op_err) begin
        seen_err++;
        chk("err_no_valid", int'(ctrl_valid), 0);
      end
      if (ctrl_valid && ctrl_ready) begin
        if (q.size() == 0) chk("unexpected_step", int'({ctrl, ctrl_last}), -1);
        else chk("step_ctrl_last", int'({ctrl, ctrl_last}), int'(q.pop_front()));
      end
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk_reset_state("reset");
    ctrl_ready = 1'b1;
    send(0, 0);
    chk("add_ctrl", int'(ctrl), int'(cw_of(0)));
    chk("add_last", int'(ctrl_last), 1);
    wait_idle();
    send(10, 3);
    for (int i = 1; i <= 3; i++) begin
      chk("sll_busy", int'(busy), 1);
      chk("sll_last", int'(ctrl_last), int'(i == 3));
      @(posedge clk);
      #1;
    end
    chk("sll_done", int'(op_ready), 1);
    wait_idle();
    send(14, 2);
    ctrl_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("ror_hold_ctrl", int'(ctrl), int'(cw_of(14)));
      chk("ror_hold_valid", int'(ctrl_valid), 1);
      @(posedge clk);
      #1;
    end
    ctrl_ready = 1'b1;
    wait_idle();
    send(15, 3);
    chk("ill_err", int'(op_err), 1);
    chk("ill_ready", int'(op_ready), 1);
    @(posedge clk);
    #1 chk("ill_err_pulse", int'(op_err), 0);
    chk("ill_no_valid", int'(ctrl_valid), 0);
    send(12, 0);
    chk("sra0_ctrl", int'(ctrl), 0);
    chk("sra0_last", int'(ctrl_last), 1);
    wait_idle();
    for (int op = 0; op < 15; op++) begin
      send(op, (op >= 9) ? ((op == 10) ? 15 : op - 7) : 5);
      wait_idle();
    end
    q.push_back({cw_of(9), 1'b0});
    op_code = 4'd9;
    op_shamt = 4'd5;
    op_valid = 1'b1;
    @(posedge clk);
    #1 op_valid = 1'b0;
    @(posedge clk);
    #1 ctrl_ready = 1'b0;
    @(negedge clk);
    chk("sla_step2_ctrl", int'(ctrl), int'(cw_of(9)));
    chk("sla_step2_last", int'(ctrl_last), 0);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk_reset_state("midrst");
    ctrl_ready = 1'b1;
    send(6, 0);
    chk("mov_after_rst", int'(ctrl_valid), 1);
    wait_idle();
    chk("op_err_count", seen_err, exp_err);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
